// File: rtl/stopwatch_ctrl_if.sv
// rtl/stopwatch_ctrl_if.sv - button, counter-chain and display signals of the stopwatch controller
interface stopwatch_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  start_stop;
  logic                  clear;
  logic                  lap;
  logic [4*DIGITS-1:0]   digits;
  logic [DIGITS-1:0]     cnt_en;
  logic                  cnt_clr;
  logic [4*DIGITS-1:0]   disp;
  logic                  running;
  logic                  lap_active;
  logic                  wrap;

  modport master (
    output start_stop, clear, lap, digits,
    input  cnt_en, cnt_clr, disp, running, lap_active, wrap
  );

  modport slave (
    input  start_stop, clear, lap, digits,
    output cnt_en, cnt_clr, disp, running, lap_active, wrap
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - run/pause/lap sequencer for a chain of external BCD decade counters
module stopwatch_ctrl #(
  parameter int PRESCALE = 100000,
  parameter int DIGITS   = 4
) (
  input  logic              clk,
  input  logic              rst,
  stopwatch_ctrl_if.slave   bus
);
  localparam int            PW    = $clog2(PRESCALE);
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {CLR, IDLE, RUN, PAUSE} state_t;

  state_t              state;
  logic [PW-1:0]       presc;
  logic [4*DIGITS-1:0] latch;
  logic [DIGITS-1:0]   casc;
  logic                chain;

  // Digit i may advance only when every lower digit reads 9; chain ends as "all nines".
  always_comb begin
    casc  = '0;
    chain = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      casc[i] = chain;
      chain   = chain & (bus.digits[4*i +: 4] == 4'd9);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= CLR;
      bus.cnt_clr    <= 1'b1;
      bus.cnt_en     <= '0;
      bus.wrap       <= 1'b0;
      bus.running    <= 1'b0;
      bus.lap_active <= 1'b0;
      presc          <= '0;
      latch          <= '0;
    end else begin
      bus.cnt_en <= '0;
      bus.wrap   <= 1'b0;
      if (state == CLR) begin
        state       <= IDLE;
        bus.cnt_clr <= 1'b0;
      end else if (bus.clear) begin
        state          <= CLR;
        bus.cnt_clr    <= 1'b1;
        bus.running    <= 1'b0;
        bus.lap_active <= 1'b0;
        presc          <= '0;
      end else if (bus.start_stop) begin
        // Prescaler holds here so a tick suppressed by the toggle fires right after resume.
        if (state == RUN) begin
          state       <= PAUSE;
          bus.running <= 1'b0;
        end else begin
          state       <= RUN;
          bus.running <= 1'b1;
        end
      end else begin
        if (state == RUN) begin
          if (presc == PLAST) begin
            presc      <= '0;
            bus.cnt_en <= casc;
            bus.wrap   <= chain;
          end else begin
            presc <= presc + PW'(1);
          end
        end
        if (bus.lap) begin
          if (state == RUN && !bus.lap_active) begin
            latch          <= bus.digits;
            bus.lap_active <= 1'b1;
          end else begin
            bus.lap_active <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.disp = bus.lap_active ? latch : bus.digits;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed bench with attached BCD counters and an arithmetic stopwatch model
module tb_stopwatch_ctrl;
  localparam int PS = 4;
  localparam int D  = 4;
  localparam int M_CLR = 0, M_IDLE = 1, M_RUN = 2, M_PAUSE = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  stopwatch_ctrl_if #(.DIGITS(D)) bus();

  stopwatch_ctrl #(.PRESCALE(PS), .DIGITS(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_fail = 0;
  bit         chk_en = 1'b0;
  logic [15:0] ctr;
  int         m_state, m_p, m_lv, m_v;
  bit         m_la, e_clr, e_wrap, e_run;
  logic [3:0] e_en;
  int         n_clr, n_en0, n_en1, n_any;
  bit         found;

  function automatic int bcd2int(logic [15:0] b);
    int r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(b[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(int v);
    logic [15:0] r;
    int t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic check(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_CLR;
    m_p     = 0;
    m_la    = 1'b0;
    m_lv    = 0;
    e_clr   = 1'b1;
    e_en    = '0;
    e_wrap  = 1'b0;
    e_run   = 1'b0;
  endtask

  // Stopwatch value kept as an integer; digit i advances when value mod 10^i is all nines.
  task automatic model_edge(input bit ss, input bit cl, input bit lp);
    int v_pre = m_v;
    int pw;
    if (e_clr) m_v = 0;
    else if (e_en[0]) m_v = (m_v + 1) % 10000;
    e_en   = '0;
    e_wrap = 1'b0;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_state == M_CLR) begin
      m_state = M_IDLE;
      e_clr   = 1'b0;
    end else if (cl) begin
      m_state = M_CLR;
      e_clr   = 1'b1;
      m_p     = 0;
      m_la    = 1'b0;
      e_run   = 1'b0;
    end else if (ss) begin
      m_state = (m_state == M_RUN) ? M_PAUSE : M_RUN;
      e_run   = (m_state == M_RUN);
    end else begin
      if (m_state == M_RUN) begin
        if (m_p == PS - 1) begin
          m_p = 0;
          pw  = 1;
          for (int i = 0; i < D; i++) begin
            e_en[i] = ((v_pre % pw) == pw - 1);
            pw      = pw * 10;
          end
          e_wrap = (v_pre == 9999);
        end else begin
          m_p++;
        end
      end
      if (lp) begin
        if (m_state == M_RUN && !m_la) begin
          m_la = 1'b1;
          m_lv = v_pre;
        end else begin
          m_la = 1'b0;
        end
      end
    end
  endtask

  task automatic cyc(input bit ss, input bit cl, input bit lp);
    logic [3:0] en_s;
    logic       clr_s;
    bus.start_stop = ss;
    bus.clear      = cl;
    bus.lap        = lp;
    en_s  = bus.cnt_en;
    clr_s = bus.cnt_clr;
    @(posedge clk);
    #1;
    if (clr_s) ctr = '0;
    else begin
      for (int i = 0; i < D; i++)
        if (en_s[i]) ctr[4*i +: 4] = (ctr[4*i +: 4] == 4'd9) ? 4'd0 : ctr[4*i +: 4] + 4'd1;
    end
    bus.digits = ctr;
    model_edge(ss, cl, lp);
    if (clr_s) n_clr++;
    if (bus.cnt_en[0]) n_en0++;
    if (bus.cnt_en[1]) n_en1++;
    if (bus.cnt_en != '0) n_any++;
    bus.start_stop = 1'b0;
    bus.clear      = 1'b0;
    bus.lap        = 1'b0;
  endtask

  task automatic load(input logic [15:0] b);
    ctr        = b;
    bus.digits = b;
    m_v        = bcd2int(b);
  endtask

  task automatic find_tick(output bit f);
    f = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc(0, 0, 0);
      if (bus.cnt_en != '0) begin
        f = 1'b1;
        break;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cnt_en", int'(bus.cnt_en), int'(e_en));
      check("cnt_clr", int'(bus.cnt_clr), int'(e_clr));
      check("running", int'(bus.running), int'(e_run));
      check("lap_active", int'(bus.lap_active), int'(m_la));
      check("wrap", int'(bus.wrap), int'(e_wrap));
      check("disp", int'(bus.disp), int'(m_la ? int2bcd(m_lv) : int2bcd(m_v)));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.start_stop = 1'b0;
    bus.clear      = 1'b0;
    bus.lap        = 1'b0;
    ctr            = '0;
    bus.digits     = '0;
    m_v            = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;

    n_clr = 0;
    n_any = 0;
    repeat (20) cyc(0, 0, 0);
    check("reset_clr_cycles", n_clr, 1);
    check("idle_no_en", n_any, 0);
    check("idle_running", int'(bus.running), 0);
    check("idle_disp", int'(bus.disp), 0);

    n_en0 = 0;
    n_en1 = 0;
    cyc(1, 0, 0);
    repeat (40) cyc(0, 0, 0);
    check("cadence_en0_pulses", n_en0, 10);
    check("cadence_en1_pulses", n_en1, 1);
    cyc(0, 0, 0);
    check("cadence_digits", int'(bus.digits), 'h0010);

    load(16'h9999);
    find_tick(found);
    check("wrap_tick_found", int'(found), 1);
    check("wrap_cnt_en", int'(bus.cnt_en), 'hF);
    check("wrap_pulse", int'(bus.wrap), 1);
    cyc(0, 0, 0);
    check("wrap_digits", int'(bus.digits), 'h0000);

    load(16'h0199);
    find_tick(found);
    check("cascade_tick_found", int'(found), 1);
    check("cascade_cnt_en", int'(bus.cnt_en), 'h7);
    check("cascade_no_wrap", int'(bus.wrap), 0);
    cyc(0, 0, 0);
    check("cascade_digits", int'(bus.digits), 'h0200);

    find_tick(found);
    check("pause_tick_found", int'(found), 1);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    check("paused_running", int'(bus.running), 0);
    n_any = 0;
    repeat (10) cyc(0, 0, 0);
    check("paused_no_en", n_any, 0);
    cyc(1, 0, 0);
    check("resume_running", int'(bus.running), 1);
    cyc(0, 0, 0);
    check("resume_plus1_en", int'(bus.cnt_en), 0);
    cyc(0, 0, 0);
    check("resume_plus2_en0", int'(bus.cnt_en[0]), 1);

    cyc(0, 0, 0);
    load(16'h0037);
    cyc(0, 0, 1);
    check("lap_set", int'(bus.lap_active), 1);
    n_en0 = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(0, 0, 0);
      if (n_en0 == 3) break;
    end
    cyc(0, 0, 0);
    check("lap_frozen_disp", int'(bus.disp), 'h0037);
    check("lap_live_digits", int'(bus.digits), 'h0040);
    cyc(0, 0, 1);
    check("lap_release_disp", int'(bus.disp), 'h0040);
    check("lap_release_flag", int'(bus.lap_active), 0);

    cyc(0, 0, 1);
    check("lap_refreeze", int'(bus.lap_active), 1);
    n_clr = 0;
    cyc(1, 1, 1);
    check("simul_cnt_clr", int'(bus.cnt_clr), 1);
    check("simul_running", int'(bus.running), 0);
    check("simul_lap", int'(bus.lap_active), 0);
    cyc(0, 0, 0);
    check("simul_idle_clr", int'(bus.cnt_clr), 0);
    cyc(0, 0, 0);
    check("simul_disp", int'(bus.disp), 0);
    cyc(0, 0, 0);
    check("simul_clr_once", n_clr, 1);

    cyc(1, 0, 0);
    repeat (3) cyc(0, 0, 0);
    check("pre_rst_running", int'(bus.running), 1);
    rst = 1'b1;
    model_reset();
    #2;
    check("async_rst_running", int'(bus.running), 0);
    check("async_rst_clr", int'(bus.cnt_clr), 1);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    rst = 1'b0;
    cyc(0, 0, 0);
    check("post_rst_clr", int'(bus.cnt_clr), 0);
    check("post_rst_digits", int'(bus.digits), 0);
    repeat (2) cyc(0, 0, 0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
